// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory word, RAM handshake state and the arbiter FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    // Returned to the requester in place of RAM data when a transaction is aborted.
    localparam word_t ABORT_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// bounded fetch starvation, a per-grant timeout and a sticky fault flag.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

    arb_state_t state, next_state;
    logic [3:0] starve_cnt, starve_nxt;
    logic [7:0] tmo_cnt;
    logic       d_req, owned, abort, done;

    function automatic arb_state_t arbitrate(input logic d_pend, input logic i_pend,
                                             input logic [3:0] starve);
        if (d_pend && starve < STARVE_LIM) return DGRANT;
        if (i_pend)                        return IGRANT;
        if (d_pend)                        return DGRANT;
        return IDLE;
    endfunction

    // The starvation count used for re-arbitration already includes the
    // completion happening this cycle, so the fetch wins right after the limit.
    always_comb begin
        d_req = dREN | dWEN;
        owned = 1'b0;
        case (state)
            DGRANT:  owned = d_req;
            IGRANT:  owned = iREN;
            default: owned = 1'b0;
        endcase
        abort = owned && (ramstate == ERROR || tmo_cnt == TMO_LIM);
        done  = owned && (ramstate == ACCESS || abort);

        if (!iREN)
            starve_nxt = '0;
        else if (done && state == IGRANT)
            starve_nxt = '0;
        else if (done && state == DGRANT && starve_cnt < STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
        else
            starve_nxt = starve_cnt;

        if (state == IDLE || done)
            next_state = arbitrate(d_req, iREN, starve_nxt);
        else if (!owned)
            next_state = IDLE;
        else
            next_state = state;
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            default: ;
        endcase
        iwait = !(done && state == IGRANT);
        dwait = !(done && state == DGRANT);
        iload = (abort && state == IGRANT) ? ABORT_WORD : ramload;
        dload = (abort && state == DGRANT) ? ABORT_WORD : ramload;
    end

    // The timeout counter restarts whenever a new grant may begin, which covers
    // idle cycles, completions and dropped requests alike.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_nxt;
            if (abort)
                err <= 1'b1;
            if (state == IDLE || done || !owned)
                tmo_cnt <= '0;
            else if (ramstate != ACCESS && tmo_cnt != 8'hFF)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a bus-ownership model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int    STARVE = 4;
    localparam int    TMO    = 255;
    localparam word_t BAD    = 32'hBAD1_BAD1;

    logic      CLK = 1'b0;
    logic      RST = 1'b0;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    word_t     iload, dload, ramaddr, ramstore;
    logic      iwait, dwait, ramREN, ramWEN, err;
    ramstate_t ramstate = FREE;

    int        tests = 0, fails = 0;
    int        cyc = 0, busy_cnt = 0, lat = 1, wen_cnt = 0;
    bit        auto_mode = 1'b1;
    ramstate_t man_state = FREE;

    int        done_kind[$], done_cyc[$];
    word_t     done_val[$], done_addr[$], done_store[$];

    // Model: who owns the bus (0 none, 1 data, 2 fetch), data wins in a row
    // while a fetch waits, and stalled cycles of the current grant.
    int        owner = 0, streak = 0, stall = 0;
    bit        m_err = 1'b0;

    mem_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic bit owned();
        case (owner)
            1:       return dREN | dWEN;
            2:       return iREN;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit failing();
        return owned() && (ramstate == ERROR || stall == TMO);
    endfunction

    function automatic bit finishing();
        return owned() && (ramstate == ACCESS || failing());
    endfunction

    function automatic int pick(input bit d, input bit i, input int s);
        if (d && s < STARVE) return 1;
        if (i) return 2;
        if (d) return 1;
        return 0;
    endfunction

    always @(posedge CLK or posedge RST) begin
        bit fin, fl, still;
        int s;
        if (RST) begin
            owner = 0; streak = 0; stall = 0; m_err = 1'b0;
        end else begin
            still = owned();
            fl    = failing();
            fin   = finishing();
            if (!iREN)                     s = 0;
            else if (fin && owner == 2)    s = 0;
            else if (fin && owner == 1)    s = (streak + 1 > STARVE) ? STARVE : streak + 1;
            else                           s = streak;
            if (fl) m_err = 1'b1;
            if (owner == 0 || fin) begin
                owner = pick(dREN | dWEN, iREN, s);
                stall = 0;
            end else if (!still) begin
                owner = 0;
                stall = 0;
            end else if (ramstate != ACCESS) begin
                stall++;
            end
            streak = s;
        end
    end

    // RAM responder: ACCESS on the lat-th consecutive strobed cycle, or a fixed state.
    always @(posedge CLK) begin
        cyc++;
        #2;
        ramload = 32'hC0DE_0000 + word_t'(cyc);
        if (!auto_mode)
            ramstate = man_state;
        else if (ramREN || ramWEN)
            ramstate = (busy_cnt + 1 >= lat) ? ACCESS : BUSY;
        else
            ramstate = FREE;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, need 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic compareAll();
        bit    e_ren, e_wen;
        word_t e_addr, e_store;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        if (owner == 1) begin
            e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
        end else if (owner == 2) begin
            e_ren = 1'b1; e_addr = iaddr;
        end
        checkOutput("ramREN", 32'(ramREN), 32'(e_ren));
        checkOutput("ramWEN", 32'(ramWEN), 32'(e_wen));
        checkOutput("ramaddr", ramaddr, e_addr);
        checkOutput("ramstore", ramstore, e_store);
        checkOutput("iwait", 32'(iwait), 32'(!(owner == 2 && finishing())));
        checkOutput("dwait", 32'(dwait), 32'(!(owner == 1 && finishing())));
        checkOutput("iload", iload, (owner == 2 && failing()) ? BAD : ramload);
        checkOutput("dload", dload, (owner == 1 && failing()) ? BAD : ramload);
        checkOutput("err", 32'(err), 32'(m_err));
    endtask

    task automatic logDone(input int kind, input word_t val);
        done_kind.push_back(kind);
        done_cyc.push_back(cyc);
        done_val.push_back(val);
        done_addr.push_back(ramaddr);
        done_store.push_back(ramstore);
    endtask

    task automatic tick();
        @(negedge CLK);
        compareAll();
        if (!dwait) logDone(1, dload);
        if (!iwait) logDone(2, iload);
        if (ramWEN) wen_cnt++;
        if ((ramREN || ramWEN) && ramstate != ACCESS) busy_cnt++;
        else busy_cnt = 0;
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit i_ren, input word_t i_addr, input bit d_ren,
                                 input bit d_wen, input word_t d_addr, input word_t d_store);
        iREN = i_ren; iaddr = i_addr;
        dREN = d_ren; dWEN = d_wen; daddr = d_addr; dstore = d_store;
    endtask

    task automatic waitDone(input int target, input int bound);
        int k;
        k = 0;
        while (done_kind.size() < target && k < bound) begin
            tick();
            k++;
        end
        checkOutput("done_count", done_kind.size(), target);
    endtask

    initial begin
        int b, w, start;
        int exp_order[7] = '{1, 1, 1, 1, 2, 1, 1};

        applyStimulus(0, '0, 0, 0, '0, '0);
        #1 RST = 1'b1;
        @(negedge CLK);
        checkOutput("rst_ramREN", 32'(ramREN), 0);
        checkOutput("rst_ramWEN", 32'(ramWEN), 0);
        checkOutput("rst_ramaddr", ramaddr, 0);
        checkOutput("rst_iwait", 32'(iwait), 1);
        checkOutput("rst_dwait", 32'(dwait), 1);
        checkOutput("rst_err", 32'(err), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        tick();

        // Single fetch, ACCESS on its third grant cycle.
        lat = 3; b = done_kind.size(); w = wen_cnt;
        applyStimulus(1, 32'h40, 0, 0, '0, '0); start = cyc;
        waitDone(b + 1, 20);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(); tick();
        checkOutput("fetch_kind", done_kind[b], 2);
        checkOutput("fetch_latency", done_cyc[b] - start, 3);
        checkOutput("fetch_data", done_val[b], 32'hC0DE_0000 + word_t'(done_cyc[b]));
        checkOutput("fetch_addr", done_addr[b], 32'h40);
        checkOutput("fetch_once", done_kind.size() - b, 1);
        checkOutput("fetch_no_wen", wen_cnt - w, 0);

        // Data and fetch rise together and stay high: four data grants, then the fetch.
        lat = 2; b = done_kind.size();
        applyStimulus(1, 32'h200, 1, 0, 32'h100, '0); start = cyc;
        waitDone(b + 7, 60);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(); tick();
        for (int k = 0; k < 7; k++)
            checkOutput($sformatf("order%0d", k), done_kind[b + k], exp_order[k]);
        checkOutput("data_first_latency", done_cyc[b] - start, 2);
        checkOutput("fetch_no_bubble", done_cyc[b + 4] - done_cyc[b + 3], 2);
        checkOutput("data_addr", done_addr[b], 32'h100);
        checkOutput("starved_fetch_addr", done_addr[b + 4], 32'h200);

        // Store.
        lat = 3; b = done_kind.size(); w = wen_cnt;
        applyStimulus(0, '0, 0, 1, 32'h80, 32'hDEAD_BEEF); start = cyc;
        waitDone(b + 1, 20);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick();
        checkOutput("store_kind", done_kind[b], 1);
        checkOutput("store_latency", done_cyc[b] - start, 3);
        checkOutput("store_wen_cycles", wen_cnt - w, 3);
        checkOutput("store_data", done_store[b], 32'hDEAD_BEEF);
        checkOutput("store_addr", done_addr[b], 32'h80);

        // Requester gives up mid-grant.
        lat = 4; b = done_kind.size();
        applyStimulus(0, '0, 1, 0, 32'h44, '0);
        tick(); tick();
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(); tick(); tick();
        checkOutput("drop_no_done", done_kind.size() - b, 0);

        // RAM reports ERROR during a data grant.
        checkOutput("err_before", 32'(err), 0);
        man_state = ERROR; auto_mode = 1'b0; b = done_kind.size();
        applyStimulus(0, '0, 1, 0, 32'h10, '0);
        waitDone(b + 1, 5);
        applyStimulus(0, '0, 0, 0, '0, '0);
        man_state = FREE; auto_mode = 1'b1;
        tick();
        checkOutput("error_kind", done_kind[b], 1);
        checkOutput("error_load", done_val[b], BAD);
        checkOutput("error_err", 32'(err), 1);

        // Reset asserted in the middle of a data grant.
        lat = 5; b = done_kind.size();
        applyStimulus(0, '0, 1, 0, 32'h300, '0);
        tick(); tick();
        #2 RST = 1'b1;
        #1;
        checkOutput("midrst_ramREN", 32'(ramREN), 0);
        checkOutput("midrst_ramaddr", ramaddr, 0);
        checkOutput("midrst_dwait", 32'(dwait), 1);
        checkOutput("midrst_err", 32'(err), 0);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick();
        RST = 1'b0;
        tick(); tick();
        checkOutput("midrst_no_done", done_kind.size() - b, 0);

        // RAM stays BUSY until the grant times out.
        man_state = BUSY; auto_mode = 1'b0; b = done_kind.size();
        applyStimulus(1, 32'h500, 0, 0, '0, '0); start = cyc;
        waitDone(b + 1, 300);
        applyStimulus(0, '0, 0, 0, '0, '0);
        man_state = FREE; auto_mode = 1'b1;
        tick(); tick(); tick();
        checkOutput("tmo_kind", done_kind[b], 2);
        checkOutput("tmo_latency", done_cyc[b] - start, 256);
        checkOutput("tmo_load", done_val[b], BAD);
        checkOutput("tmo_addr", done_addr[b], 32'h500);
        checkOutput("tmo_err", 32'(err), 1);

        lat = 1; b = done_kind.size();
        applyStimulus(1, 32'h600, 0, 0, '0, '0);
        waitDone(b + 1, 10);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick();
        checkOutput("after_tmo_data", done_val[b], 32'hC0DE_0000 + word_t'(done_cyc[b]));
        checkOutput("err_sticky", 32'(err), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
